inst_fetch: RTL
===============

// Module: inst_fetch
// PURPOSE
//  IF stage. Owns the PC and issues one instruction read per cycle on ibus.
//  Produces pipe_if (PC and translated address) one cycle after each accepted request; the
//  same cycle, ibus_valid/ibus_rddata reach inst_decode.
//  Applies exception redirects (immediate) and branch redirects (after the delay slot).
//  Honours the ID back-pressure (ready_i).
// PARAMETERS
//  RESET_VEC   32'hbfc0_0000  PC loaded on reset
//  N_ISSUE     1              fetch width; only 1 is supported, later ones tie to '0
// PORTS
//  clk            in   1    clock
//  rst            in   1    synchronous active-high reset
//  ready_i        in   1    ID can accept (inst_decode ready_o)
//  except_req     in   except_req_t  .valid flush, .target handler PC
//  branch_valid   in   1    ID resolved a taken branch/jump this cycle
//  branch_target  in   32   its target address
//  ibus_read      out  1    read request
//  ibus_addr      out  32   physical address of request
//  ibus_stall     in   1    bus not accepting; request held stable
//  ibus_valid     in   1    read data valid (to ID, passes through)
//  pipe_if        out  pipe_if_t  valid, mmu_iaddr_resp[0].{vaddr,paddr}, iaddr_err
// BEHAVIOUR
//  Reset:
//   - pc=RESET_VEC, pipe_if='0, ibus_read=0, state=RUN, pend_target=0.
//  Request:
//   - ibus_read = ~rst & ready_i & ~except_req.valid & (pc[1:0]==0).
//   - ibus_addr = mmu(pc).
//   - Accept = ibus_read & ~ibus_stall.
//  PC update priority (registered):
//   1. except_req.valid: pc<=target, state<=RUN, pipe_if.valid<=0; any in-flight
//      response is invalid.
//   2. Accept & state==DS_PEND: pc<=pend_target, state<=RUN.
//   3. branch_valid & state==RUN: the delay slot is the request at pc this cycle.
//      - If accepted the same cycle: pc<=branch_target.
//      - Else: pend_target<=branch_target, state<=DS_PEND.
//   4. Accept: pc<=pc+4 (32-bit wrap, no carry out).
//   5. Otherwise hold.
//  pipe_if update:
//   - On Accept: pipe_if<={valid=1, vaddr=pc, paddr=mmu(pc), iaddr_err=0}.
//   - On ~ready_i: hold pipe_if; ID stores the returned word itself.
//   - ready_i & ~Accept: pipe_if.valid<=0.
//   - Latency: request cycle n, pipe_if/ibus_valid in cycle n+1.
//  Misaligned pc (pc[1:0]!=0):
//   - No bus request.
//   - pipe_if<={valid=1, vaddr=pc, iaddr_err=1}.
//   - pc holds until except_req redirects it.
//  FSM RUN <-> DS_PEND:
//   - DS_PEND is left only by an accept of the delay slot or by an exception.
//   - branch_valid in DS_PEND is illegal (ID stalls) and is ignored.
//  Simultaneous events:
//   - except_req overrides branch_valid and ibus_stall.
//   - rst overrides everything.
//  Reset mid-request: the request drops the next cycle; the stale ibus_valid beat is
//   qualified off by pipe_if.valid=0.
// STRUCTURE
//  Shared package (cpu_defs):
//   - pipe_if_t and mmu_resp_t (vaddr, paddr, uncached)
//   - fetch state enum {FS_RUN, FS_DS_PEND}
//   - RESET_VEC constant
//  Sub-module mmu_fixed (combinational, vaddr->paddr):
//   - kseg0/1: clear bits [31:29]
//   - otherwise identity
//   - reused later by the dbus path
// TESTING
//  1. Reset release, ibus_stall=0, ready_i=1 -> ibus_addr 1fc00000,1fc00004,...;
//     pipe_if.vaddr trails by one cycle.
//  2. ibus_stall=1 for 3 cycles at pc bfc00008 -> addr held stable; pipe_if.valid=0
//     those cycles; then 08,0c resume.
//  3. ready_i=0 for 2 cycles -> pc and pipe_if frozen; no ibus_read; resume without
//     a lost or duplicated PC.
//  4. branch_valid target bfc00100 while fetching bfc0000c -> 0c is fetched (delay
//     slot), next fetch 100. Repeat with ibus_stall on 0c: DS_PEND, then 0c, then 100.
//  5. except_req target bfc00380 with branch_valid and ibus_stall both set -> next
//     pipe_if.valid=0, next pc 380, state RUN.
//  6. except_req to bfc00382 -> no ibus_read; pipe_if.iaddr_err=1, vaddr bfc00382.

Source files
------------

// File: rtl/cpu_defs.sv
// Shared CPU definitions: fetch/MMU bundles, fetch FSM states,
// reset vector.
package cpu_defs;

  localparam logic [31:0] RESET_VEC = 32'hbfc0_0000;
  localparam int N_ISSUE = 1;

  typedef struct packed {
    logic [31:0] vaddr;
    logic [31:0] paddr;
    logic        uncached;
  } mmu_resp_t;

  typedef struct packed {
    logic                      valid;
    mmu_resp_t [N_ISSUE-1:0]   mmu_iaddr_resp;
    logic                      iaddr_err;
  } pipe_if_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] target;
  } except_req_t;

  typedef enum logic {
    FS_RUN,
    FS_DS_PEND
  } fetch_state_t;

  // kseg0 (100) and kseg1 (101) are the unmapped windows
  function automatic logic is_kseg01(
    input logic [31:0] va
  );
    return va[31:30] == 2'b10;
  endfunction

endpackage

// File: rtl/mmu_fixed.sv
// Fixed-mapping MMU: kseg0/kseg1 strip the top three bits,
// every other segment maps one-to-one.
module mmu_fixed
  import cpu_defs::*;
(
  input  logic [31:0] vaddr,
  output mmu_resp_t   resp
);

  always_comb begin
    resp = '0;
    resp.vaddr = vaddr;
    if (is_kseg01(vaddr)) begin
      resp.paddr    = {3'b000, vaddr[28:0]};
      resp.uncached = vaddr[29];
    end else begin
      resp.paddr    = vaddr;
      resp.uncached = 1'b0;
    end
  end

endmodule

// File: rtl/inst_fetch.sv
// IF stage: owns the PC, issues one ibus read per cycle and
// applies exception and delayed branch redirects.
module inst_fetch
  import cpu_defs::*;
#(
  parameter logic [31:0] RESET_VEC = cpu_defs::RESET_VEC,
  parameter int          N_ISSUE   = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ready_i,
  input  except_req_t  except_req,
  input  logic         branch_valid,
  input  logic [31:0]  branch_target,
  output logic         ibus_read,
  output logic [31:0]  ibus_addr,
  input  logic         ibus_stall,
  input  logic         ibus_valid,
  output pipe_if_t     pipe_if
);

  localparam logic [31:0] PC_STEP = 32'(4 * N_ISSUE);

  fetch_state_t state;
  fetch_state_t state_nx;

  logic [31:0] pc;
  logic [31:0] pc_nx;
  logic [31:0] pend_target;
  logic [31:0] pend_nx;
  pipe_if_t    pipe_nx;

  mmu_resp_t pc_map;
  logic      aligned;
  logic      accept;

  // read data is consumed by ID directly
  logic unused_ok;
  assign unused_ok = ibus_valid;

  mmu_fixed u_mmu (
    .vaddr (pc),
    .resp  (pc_map)
  );

  assign aligned   = pc[1:0] == 2'b00;
  assign ibus_read = ~rst & ready_i
                   & ~except_req.valid & aligned;
  assign ibus_addr = pc_map.paddr;
  assign accept    = ibus_read & ~ibus_stall;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= FS_RUN;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    if (except_req.valid) begin
      state_nx = FS_RUN;
    end else begin
      unique case (state)
        FS_DS_PEND: begin
          if (accept) state_nx = FS_RUN;
        end
        FS_RUN: begin
          if (branch_valid && !accept)
            state_nx = FS_DS_PEND;
        end
        default: state_nx = FS_RUN;
      endcase
    end
  end

  always_comb begin
    pc_nx   = pc;
    pend_nx = pend_target;
    if (except_req.valid) begin
      pc_nx = except_req.target;
    end else if (accept && state == FS_DS_PEND) begin
      pc_nx = pend_target;
    end else if (branch_valid && state == FS_RUN) begin
      if (accept) pc_nx = branch_target;
      else        pend_nx = branch_target;
    end else if (accept) begin
      pc_nx = pc + PC_STEP;
    end
  end

  always_comb begin
    pipe_nx = pipe_if;
    if (except_req.valid) begin
      pipe_nx.valid = 1'b0;
    end else if (!ready_i) begin
      pipe_nx = pipe_if;
    end else if (accept || !aligned) begin
      pipe_nx = '0;
      pipe_nx.valid = 1'b1;
      pipe_nx.mmu_iaddr_resp[0] = pc_map;
      pipe_nx.iaddr_err = ~aligned;
    end else begin
      pipe_nx.valid = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc          <= RESET_VEC;
      pend_target <= '0;
      pipe_if     <= '0;
    end else begin
      pc          <= pc_nx;
      pend_target <= pend_nx;
      pipe_if     <= pipe_nx;
    end
  end

endmodule
